// File: rtl/bmi_seq.sv
// rtl/bmi_seq.sv - multi-cycle BMI engine: shift-add square, restoring divide, saturate and classify
module bmi_seq #(
    parameter int W_WIDTH  = 8,
    parameter int H_WIDTH  = 8,
    parameter int SCALE    = 10000,
    parameter int T_UNDER  = 18,
    parameter int T_NORMAL = 25,
    parameter int T_OVER   = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               start,
    input  logic [W_WIDTH-1:0] weight,
    input  logic [H_WIDTH-1:0] height,
    output logic               busy,
    output logic               done,
    output logic [7:0]         bmi,
    output logic [1:0]         category,
    output logic               error
);

    localparam int NUM_W = W_WIDTH + 14;
    localparam int DEN_W = 2 * H_WIDTH;
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic [7:0]       TH_UNDER  = 8'(T_UNDER);
    localparam logic [7:0]       TH_NORMAL = 8'(T_NORMAL);
    localparam logic [7:0]       TH_OVER   = 8'(T_OVER);
    localparam logic [CNT_W-1:0] SQ_LAST   = CNT_W'(H_WIDTH - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(NUM_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_DIVIDE,
        S_CLASSIFY,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_W-1:0]   num;
    logic [NUM_W-1:0]   quo;
    logic [H_WIDTH-1:0] h_bits;
    logic [DEN_W-1:0]   h_shift;
    logic [DEN_W-1:0]   prod;
    logic [DEN_W-1:0]   den;
    logic [DEN_W:0]     rem;
    logic               zero_h;

    logic [NUM_W-1:0] num_scaled;
    logic [DEN_W:0]   rem_shift;
    logic [DEN_W+1:0] rem_diff;
    logic [7:0]       bmi_sat;
    logic [1:0]       cat_next;

    assign num_scaled = NUM_W'(weight) * NUM_W'(SCALE);

    // Remainder is always below den, so the shifted value fits DEN_W+1 bits; the extra diff bit is the borrow.
    assign rem_shift = {rem[DEN_W-1:0], num[NUM_W-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, den};
    assign bmi_sat   = (|quo[NUM_W-1:8]) ? 8'hFF : quo[7:0];

    always_comb begin
        cat_next = 2'd3;
        if (bmi_sat < TH_UNDER) begin
            cat_next = 2'd0;
        end else if (bmi_sat < TH_NORMAL) begin
            cat_next = 2'd1;
        end else if (bmi_sat < TH_OVER) begin
            cat_next = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            state    <= S_IDLE;
            cnt      <= '0;
            num      <= '0;
            quo      <= '0;
            h_bits   <= '0;
            h_shift  <= '0;
            prod     <= '0;
            den      <= '0;
            rem      <= '0;
            zero_h   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bmi      <= '0;
            category <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        num     <= num_scaled;
                        h_bits  <= height;
                        h_shift <= DEN_W'(height);
                        prod    <= '0;
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= '0;
                        zero_h  <= (height == '0);
                        busy    <= 1'b1;
                        state   <= (height == '0) ? S_CLASSIFY : S_SQUARE;
                    end
                end

                S_SQUARE: begin
                    if (h_bits[0]) begin
                        prod <= prod + h_shift;
                    end
                    h_shift <= h_shift << 1;
                    h_bits  <= h_bits >> 1;
                    if (cnt == SQ_LAST) begin
                        cnt   <= '0;
                        state <= S_DIVIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Count 0 latches the finished square as the divisor; counts 1..NUM_W are the restoring steps.
                S_DIVIDE: begin
                    if (cnt == '0) begin
                        den <= prod;
                    end else begin
                        num <= num << 1;
                        if (!rem_diff[DEN_W+1]) begin
                            rem <= rem_diff[DEN_W:0];
                            quo <= {quo[NUM_W-2:0], 1'b1};
                        end else begin
                            rem <= rem_shift;
                            quo <= {quo[NUM_W-2:0], 1'b0};
                        end
                    end
                    if (cnt == DIV_LAST) begin
                        state <= S_CLASSIFY;
                    end
                    cnt <= cnt + 1'b1;
                end

                S_CLASSIFY: begin
                    if (zero_h) begin
                        bmi      <= 8'hFF;
                        category <= 2'd3;
                        error    <= 1'b1;
                    end else begin
                        bmi      <= bmi_sat;
                        category <= cat_next;
                        error    <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmi_seq.sv
// tb/tb_bmi_seq.sv - directed table and multi-cycle sequence bench for bmi_seq
module tb_bmi_seq;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       start;
    logic [7:0] weight;
    logic [7:0] height;
    logic       busy;
    logic       done;
    logic [7:0] bmi;
    logic [1:0] category;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int w;
        int h;
        int bmi;
        int cat;
        int err;
        int lat;
    } vec_t;

    vec_t vecs[16];

    bmi_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .start    (start),
        .weight   (weight),
        .height   (height),
        .busy     (busy),
        .done     (done),
        .bmi      (bmi),
        .category (category),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input int w, input int h,
                          input int e_bmi, input int e_cat, input int e_err, input int e_lat);
        int lat;
        int busy_gap;
        @(negedge clk);
        weight = 8'(w);
        height = 8'(h);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, ".busy_rise"}, int'(busy), 1);
        lat = 0;
        busy_gap = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busy_gap = 1;
        end
        chk({name, ".latency"}, lat, e_lat);
        chk({name, ".busy_held"}, busy_gap, 0);
        chk({name, ".bmi"}, int'(bmi), e_bmi);
        chk({name, ".category"}, int'(category), e_cat);
        chk({name, ".error"}, int'(error), e_err);
        @(posedge clk);
        #1;
        chk({name, ".done_fall"}, int'(done), 0);
        chk({name, ".busy_fall"}, int'(busy), 0);
        chk({name, ".bmi_hold"}, int'(bmi), e_bmi);
    endtask

    initial begin
        int k;
        int lat2;
        int saw_done;

        vecs[0]  = '{70, 175, 22, 1, 0, 32};
        vecs[1]  = '{45, 170, 15, 0, 0, 32};
        vecs[2]  = '{80, 180, 24, 1, 0, 32};
        vecs[3]  = '{80, 170, 27, 2, 0, 32};
        vecs[4]  = '{90, 170, 31, 3, 0, 32};
        vecs[5]  = '{255, 50, 255, 3, 0, 32};
        vecs[6]  = '{255, 100, 255, 3, 0, 32};
        vecs[7]  = '{1, 255, 0, 0, 0, 32};
        vecs[8]  = '{17, 100, 17, 0, 0, 32};
        vecs[9]  = '{18, 100, 18, 1, 0, 32};
        vecs[10] = '{24, 100, 24, 1, 0, 32};
        vecs[11] = '{25, 100, 25, 2, 0, 32};
        vecs[12] = '{29, 100, 29, 2, 0, 32};
        vecs[13] = '{30, 100, 30, 3, 0, 32};
        vecs[14] = '{60, 0, 255, 3, 1, 1};
        vecs[15] = '{70, 175, 22, 1, 0, 32};

        reset_n = 1'b0;
        enable  = 1'b1;
        start   = 1'b0;
        weight  = '0;
        height  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.bmi", int'(bmi), 0);
        chk("reset.category", int'(category), 0);
        chk("reset.error", int'(error), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].h,
                   vecs[i].bmi, vecs[i].cat, vecs[i].err, vecs[i].lat);
        end

        // start re-pulsed with other operands mid-operation must be ignored
        run_op("pre_repulse", 45, 170, 15, 0, 0, 32);
        @(negedge clk);
        weight = 8'd70;
        height = 8'd175;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            k++;
            @(negedge clk);
            if (k == 10) begin
                start  = 1'b1;
                weight = 8'd90;
                height = 8'd170;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("repulse.latency", k, 32);
        chk("repulse.bmi", int'(bmi), 22);
        chk("repulse.category", int'(category), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("repulse.no_requeue", int'(busy), 0);

        // start held high: back-to-back results
        @(negedge clk);
        weight = 8'd70;
        height = 8'd175;
        start  = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("held.first_latency", k, 32);
        lat2 = 0;
        do begin
            @(posedge clk);
            #1;
            lat2++;
        end while (!done && lat2 < 200);
        start = 1'b0;
        chk("held.period", lat2, 34);
        chk("held.bmi", int'(bmi), 22);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("held.idle_after", int'(busy), 0);

        // enable dropped at edge 20
        @(negedge clk);
        weight = 8'd80;
        height = 8'd170;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == 20) enable = 1'b0;
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("en_abort.busy", int'(busy), 0);
        chk("en_abort.done", int'(done), 0);
        chk("en_abort.bmi", int'(bmi), 0);
        chk("en_abort.category", int'(category), 0);
        @(negedge clk);
        enable = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("en_abort.no_done", saw_done, 0);
        run_op("after_en_abort", 70, 175, 22, 1, 0, 32);

        // reset pulsed during DIVIDE
        @(negedge clk);
        weight = 8'd90;
        height = 8'd170;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 0;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            if (e == 15) reset_n = 1'b0;
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("rst_abort.busy", int'(busy), 0);
        chk("rst_abort.bmi", int'(bmi), 0);
        chk("rst_abort.category", int'(category), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("rst_abort.no_done", saw_done, 0);
        run_op("after_rst_abort", 80, 180, 24, 1, 0, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
